// File: rtl/expu_accumulator.sv
// expu_accumulator: converts a stream of FP exp() results to unsigned fixed point and sums each vector.
// Build option EXPU_ACC_ROUND_EN: round half-up in the conversion instead of truncating.
module expu_accumulator #(
   // FPFORMAT: 0 FP32, 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT (bfloat16)
   parameter int FPFORMAT  = 4,
   parameter int ACC_INT   = 16,
   parameter int ACC_FRAC  = 16,
   parameter int CNT_WIDTH = 16,
   localparam int EXPONENT_BITS = (FPFORMAT == 1) ? 11 : (FPFORMAT == 2 || FPFORMAT == 3) ? 5 : 8,
   localparam int MANTISSA_BITS = (FPFORMAT == 0) ? 23 : (FPFORMAT == 1) ? 52 :
                                  (FPFORMAT == 2) ? 10 : (FPFORMAT == 3) ? 2 : 7,
   localparam int WIDTH = EXPONENT_BITS + MANTISSA_BITS + 1,
   localparam int BIAS  = (1 << (EXPONENT_BITS - 1)) - 1,
   localparam int ACC_W = ACC_INT + ACC_FRAC
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     in_data_i,
   input  logic                 in_last_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [ACC_W-1:0]     out_sum_o,
   output logic [CNT_WIDTH-1:0] out_count_o,
   output logic                 out_ovf_o
);
   localparam int SW = EXPONENT_BITS + 2;
   localparam int KW = $clog2(ACC_W + 1);
   localparam int PW = ACC_W + MANTISSA_BITS + 1;
   localparam logic signed [SW-1:0] C_KOFF = SW'(ACC_FRAC + 1 - BIAS);
   localparam logic signed [SW-1:0] C_KMAX = SW'(ACC_W + 1);

   typedef enum logic {ST_ACC, ST_OUT} state_t;

   state_t                 r_state;
   logic                   r_pend;
   logic                   r_s1_val, r_s1_ovf, r_s1_last;
   logic [ACC_W-1:0]       r_s1_conv, r_acc, r_out_sum;
   logic [CNT_WIDTH-1:0]   r_cnt, r_out_cnt;
   logic                   r_ovf, r_out_ovf;

   logic [EXPONENT_BITS-1:0] w_exp;
   logic [MANTISSA_BITS-1:0] w_man;
   logic signed [SW-1:0]     w_k;
   logic [PW-1:0]            w_p;
   logic [ACC_W:0]           w_v, w_rnd, w_sum;
   logic                     w_inf, w_big, w_zero, w_fire, w_conv_ovf, w_ovf_n;
   logic [ACC_W-1:0]         w_conv, w_acc_n;
   logic [CNT_WIDTH-1:0]     w_cnt_n;
   logic                     w_unused;

   // w_k is the left shift of {1,mantissa} in units of half an accumulator LSB
   assign w_exp  = in_data_i[WIDTH-2 -: EXPONENT_BITS];
   assign w_man  = in_data_i[MANTISSA_BITS-1:0];
   assign w_k    = $signed({2'b00, w_exp}) + C_KOFF;
   assign w_inf  = &w_exp;
   assign w_big  = w_k >= C_KMAX;
   assign w_zero = ~|w_exp || w_k[SW-1];
   assign w_p    = {{ACC_W{1'b0}}, 1'b1, w_man} << w_k[KW-1:0];
   assign w_v    = w_p[PW-1:MANTISSA_BITS];
`ifdef EXPU_ACC_ROUND_EN
   assign w_rnd  = {1'b0, w_v[ACC_W:1]} + {{ACC_W{1'b0}}, w_v[0]};
`else
   assign w_rnd  = {1'b0, w_v[ACC_W:1]};
`endif
   assign w_conv     = (w_inf || w_big) ? '1 : w_zero ? '0 : w_rnd[ACC_W] ? '1 : w_rnd[ACC_W-1:0];
   assign w_conv_ovf = w_inf || w_big || (!w_zero && w_rnd[ACC_W]);
   assign w_unused   = ^{in_data_i[WIDTH-1], w_p[MANTISSA_BITS-1:0], w_v[0]};

   assign w_sum   = {1'b0, r_acc} + {1'b0, r_s1_conv};
   assign w_acc_n = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
   assign w_cnt_n = &r_cnt ? r_cnt : r_cnt + 1'b1;
   assign w_ovf_n = r_ovf || r_s1_ovf || w_sum[ACC_W];

   assign in_ready_o  = !r_pend && !clear_i;
   assign w_fire      = in_valid_i && in_ready_o;
   assign out_valid_o = r_state == ST_OUT;
   assign out_sum_o   = r_out_sum;
   assign out_count_o = r_out_cnt;
   assign out_ovf_o   = r_out_ovf;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= ST_ACC;
         r_pend    <= 1'b0;
         r_s1_val  <= 1'b0;
         r_s1_ovf  <= 1'b0;
         r_s1_last <= 1'b0;
         r_s1_conv <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_out_sum <= '0;
         r_out_cnt <= '0;
         r_out_ovf <= 1'b0;
      end else if (clear_i) begin
         r_state  <= ST_ACC;
         r_pend   <= 1'b0;
         r_s1_val <= 1'b0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_s1_val <= w_fire;
         if (w_fire) begin
            r_s1_conv <= w_conv;
            r_s1_ovf  <= w_conv_ovf;
            r_s1_last <= in_last_i;
            if (in_last_i) r_pend <= 1'b1;
         end
         if (r_s1_val) begin
            r_acc <= w_acc_n;
            r_cnt <= w_cnt_n;
            r_ovf <= w_ovf_n;
            if (r_s1_last) begin
               r_state   <= ST_OUT;
               r_out_sum <= w_acc_n;
               r_out_cnt <= w_cnt_n;
               r_out_ovf <= w_ovf_n;
            end
         end
         // result held until consumed; outputs keep their values afterwards
         if (r_state == ST_OUT && out_ready_i) begin
            r_state <= ST_ACC;
            r_pend  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_expu_accumulator.sv
// tb_expu_accumulator: random and directed vectors scored against a real-arithmetic model of the accumulator.
module tb_expu_accumulator;
   logic        clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0;
   logic        in_valid_i = 1'b0, in_last_i = 1'b0, out_ready_i = 1'b1;
   logic [15:0] in_data_i = '0;
   logic        in_ready_o, out_valid_o, out_ovf_o;
   logic [31:0] out_sum_o;
   logic [15:0] out_count_o;

   typedef struct {logic [31:0] sum; logic [15:0] cnt; logic ovf; longint cyc;} exp_t;
   localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;
`ifdef EXPU_ACC_ROUND_EN
   localparam logic [31:0] TINY_SUM = 32'h0000_0001;
`else
   localparam logic [31:0] TINY_SUM = 32'h0000_0000;
`endif

   exp_t        q[$];
   exp_t        e_mon;
   logic [15:0] vec[$];
   int          total = 0, bad = 0;
   longint      cyc = 0;
   bit          force_low = 0, rand_rdy = 0;
   longint      m_sum = 0;
   int          m_cnt = 0;
   bit          m_ovf = 0;
   bit          ov_en = 0, ov_ovf = 0;
   logic [31:0] ov_sum = '0;
   logic [15:0] ov_cnt = '0;
   bit          prev_v = 0, prev_hs = 0;
   logic [31:0] h_sum;
   logic [15:0] h_cnt;
   logic        h_ovf;

   expu_accumulator dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_sum_o(out_sum_o), .out_count_o(out_count_o), .out_ovf_o(out_ovf_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;
   always @(posedge clk_i) begin
      #2;
      out_ready_i = force_low ? 1'b0 : rand_rdy ? 1'($urandom) : 1'b1;
   end

   task automatic chk(input bit ok, input string name, input longint act, input longint req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // bfloat16 value times 2^16, as real arithmetic
   function automatic longint ref_conv(input logic [15:0] d, output bit ovf);
      int  e;
      int  m;
      real v;
      e = int'(d[14:7]);
      m = int'(d[6:0]);
      ovf = 0;
      if (e == 255) begin
         ovf = 1;
         return MAXV;
      end
      if (e == 0) return 0;
      v = (1.0 + m / 128.0) * (2.0 ** (e - 127)) * 65536.0;
`ifdef EXPU_ACC_ROUND_EN
      v = v + 0.5;
`endif
      if (v >= 4294967296.0) begin
         ovf = 1;
         return MAXV;
      end
      return longint'($floor(v));
   endfunction

   task automatic model_beat(input logic [15:0] d, input bit last);
      bit     o;
      longint v;
      exp_t   e;
      v = ref_conv(d, o);
      m_sum += v;
      if (m_sum > MAXV) begin
         m_sum = MAXV;
         o = 1;
      end
      if (m_cnt < 65535) m_cnt++;
      m_ovf |= o;
      if (last) begin
         e.sum = ov_en ? ov_sum : m_sum[31:0];
         e.cnt = ov_en ? ov_cnt : m_cnt[15:0];
         e.ovf = ov_en ? ov_ovf : m_ovf;
         e.cyc = cyc + 2;
         q.push_back(e);
         m_sum = 0;
         m_cnt = 0;
         m_ovf = 0;
      end
   endtask

   task automatic send_beat(input logic [15:0] d, input bit last);
      int t = 0;
      in_valid_i = 1'b1;
      in_data_i  = d;
      in_last_i  = last;
      @(negedge clk_i);
      while (!in_ready_o && t < 300) begin
         t++;
         @(negedge clk_i);
      end
      if (t >= 300) chk(0, "in_ready_timeout", t, 300);
      else model_beat(d, last);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
   endtask

   task automatic run_vec(input int gap);
      for (int i = 0; i < vec.size(); i++) begin
         send_beat(vec[i], i == vec.size() - 1);
         if (gap > 0) repeat ($urandom_range(0, gap)) begin
            @(posedge clk_i);
            #1;
         end
      end
   endtask

   task automatic directed(input logic [31:0] s, input logic [15:0] c, input bit o);
      ov_en = 1; ov_sum = s; ov_cnt = c; ov_ovf = o;
      run_vec(0);
      ov_en = 0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (q.size() != 0 && t < 500) begin
         @(posedge clk_i);
         t++;
      end
      if (q.size() != 0) chk(0, "drain_timeout", q.size(), 0);
      #1;
   endtask

   task automatic wait_out_valid();
      int t = 0;
      @(negedge clk_i);
      while (!out_valid_o && t < 50) begin
         t++;
         @(negedge clk_i);
      end
      if (!out_valid_o) chk(0, "out_valid_timeout", out_valid_o, 1);
   endtask

   function automatic logic [15:0] rand_data();
      int         r;
      logic [7:0] e;
      r = $urandom_range(0, 99);
      e = r < 5 ? 8'd0 : r < 8 ? 8'd255 : r < 12 ? 8'($urandom_range(140, 150)) : 8'($urandom_range(100, 135));
      return {1'($urandom), e, 7'($urandom)};
   endfunction

   // scoreboard monitor: latency, hold stability, ready behaviour and popped results
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         prev_v  = 0;
         prev_hs = 0;
      end else begin
         if (prev_hs && !clear_i) chk(in_ready_o == 1'b1, "ready_after_hs", in_ready_o, 1);
         if (out_valid_o) begin
            chk(in_ready_o == 1'b0, "ready_in_out", in_ready_o, 0);
            if (!prev_v) begin
               chk(q.size() != 0, "unexpected_out", q.size(), 1);
               if (q.size() != 0) chk(cyc == q[0].cyc, "latency", cyc, q[0].cyc);
               h_sum = out_sum_o;
               h_cnt = out_count_o;
               h_ovf = out_ovf_o;
            end else
               chk({out_sum_o, out_count_o, out_ovf_o} == {h_sum, h_cnt, h_ovf}, "hold_stable",
                   longint'(out_sum_o), longint'(h_sum));
            if (out_ready_i && q.size() != 0) begin
               e_mon = q.pop_front();
               chk(out_sum_o == e_mon.sum, "sum", out_sum_o, e_mon.sum);
               chk(out_count_o == e_mon.cnt, "count", out_count_o, e_mon.cnt);
               chk(out_ovf_o == e_mon.ovf, "ovf", out_ovf_o, e_mon.ovf);
            end
         end
         prev_v  = out_valid_o;
         prev_hs = out_valid_o && out_ready_i;
      end
   end

   initial begin
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      chk(out_valid_o == 1'b0, "rst_valid", out_valid_o, 0);
      chk(out_sum_o == 32'h0, "rst_sum", out_sum_o, 0);
      chk(out_count_o == 16'h0, "rst_count", out_count_o, 0);
      chk(out_ovf_o == 1'b0, "rst_ovf", out_ovf_o, 0);
      chk(in_ready_o == 1'b1, "rst_ready", in_ready_o, 1);
      @(posedge clk_i);
      #1;
      vec = {16'h3F80, 16'h3F00, 16'h3E80};
      directed(32'h0001_C000, 16'd3, 1'b0);
      wait_drain();
      vec = {16'h3700};
      directed(TINY_SUM, 16'd1, 1'b0);
      wait_drain();
      vec = {16'h4780};
      directed(32'hFFFF_FFFF, 16'd1, 1'b1);
      wait_drain();
      vec = {16'h3F80};
      directed(32'h0001_0000, 16'd1, 1'b0);
      wait_drain();
      vec = {16'h7F80};
      directed(32'hFFFF_FFFF, 16'd1, 1'b1);
      wait_drain();
      vec = {16'h3F80};
      directed(32'h0001_0000, 16'd1, 1'b0);
      wait_drain();
      // hold the result with a beat pending upstream
      force_low = 1;
      vec = {16'h3F80, 16'h4000};
      directed(32'h0003_0000, 16'd2, 1'b0);
      wait_out_valid();
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b1; in_data_i = 16'h3F80; in_last_i = 1'b1;
      repeat (5) @(negedge clk_i);
      force_low = 0;
      @(posedge clk_i);
      #1;
      vec = {16'h3F80};
      directed(32'h0001_0000, 16'd1, 1'b0);
      wait_drain();
      // flush mid-vector
      send_beat(16'h3F80, 1'b0);
      send_beat(16'h3F80, 1'b0);
      repeat (3) @(posedge clk_i);
      #1 clear_i = 1'b1;
      @(posedge clk_i);
      #1 clear_i = 1'b0;
      m_sum = 0; m_cnt = 0; m_ovf = 0;
      vec = {16'h3F00};
      directed(32'h0000_8000, 16'd1, 1'b0);
      wait_drain();
      // asynchronous reset while a result is held
      force_low = 1;
      vec = {16'h3F80};
      directed(32'h0001_0000, 16'd1, 1'b0);
      wait_out_valid();
      @(posedge clk_i);
      #3 rst_ni = 1'b0;
      #1 chk(out_valid_o == 1'b0, "rst_async_valid", out_valid_o, 0);
      repeat (2) @(posedge clk_i);
      q.delete();
      force_low = 0;
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      chk(out_valid_o == 1'b0, "rel_valid", out_valid_o, 0);
      chk(out_sum_o == 32'h0, "rel_sum", out_sum_o, 0);
      chk(out_count_o == 16'h0, "rel_count", out_count_o, 0);
      chk(out_ovf_o == 1'b0, "rel_ovf", out_ovf_o, 0);
      @(posedge clk_i);
      #1;
      rand_rdy = 1;
      for (int n = 0; n < 40; n++) begin
         vec.delete();
         repeat ($urandom_range(1, 8)) vec.push_back(rand_data());
         run_vec(n < 20 ? 2 : 0);
      end
      wait_drain();
      rand_rdy = 0;
      repeat (3) @(posedge clk_i);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
